// File: rtl/spi_slave_port_pkg.sv
// Shared definitions for the SPI responder port: default word width and FSM
// state encoding. The port runs SPI mode 0 only (CPOL=0, CPHA=0).
package spi_slave_port_pkg;

  // CPU-side word width
  localparam int unsigned W_CPU = 32;

  // Frame state: IDLE while deselected, ACTIVE while cs_n is low
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by an edge
// detector. rise_c/fall_c are one-clk pulses decoded from the synchronized
// level and the flop behind it.
//   clk, rst  : system clock, async active-low reset
//   din       : asynchronous input
//   rise_c    : synchronized 0->1 transition (combinational pulse)
//   fall_c    : synchronized 1->0 transition (combinational pulse)
module spi_sync_edge #(
  parameter int unsigned N_Sync = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [N_Sync-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the raw input through the chain; prev lags the synchronized level
  always_comb begin
    sync_d = {sync_q[N_Sync-2:0], din};
    prev_d = sync_q[N_Sync-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_c = sync_q[N_Sync-1] & ~prev_q;
  assign fall_c = ~sync_q[N_Sync-1] & prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder. sclk, cs_n and mosi are oversampled in the clk domain
// (clk >= 8x sclk). Received words go out on rx_data/rx_valid/rx_ack; words to
// return come in through a one-entry buffer on tx_data/tx_valid/tx_ready.
//   clk, rst           : system clock, async active-low reset
//   sclk, cs_n, mosi   : SPI bus from the master (asynchronous)
//   miso, miso_oe      : serial data to the master and its tristate enable
//   rx_data, rx_valid  : last complete received word and its valid flag
//   rx_ack             : consumer pops rx_data
//   tx_data, tx_valid  : next word to send
//   tx_ready           : transmit buffer empty
//   busy               : frame in progress
//   overrun, underrun  : one-cycle error pulses
module spi_slave_port
  import spi_slave_port_pkg::*;
#(
  parameter int unsigned W_Data  = W_CPU,
  parameter int unsigned W_Count = 6,
  parameter int unsigned N_Sync  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [W_Data-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  input  logic [W_Data-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              overrun,
  output logic              underrun
);

  logic sclk_rise_c, sclk_fall_c;
  logic cs_rise_c, cs_fall_c;

  spi_sync_edge #(.N_Sync(N_Sync)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .din    (sclk),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  spi_sync_edge #(.N_Sync(N_Sync)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .din    (cs_n),
    .rise_c (cs_rise_c),
    .fall_c (cs_fall_c)
  );

  // mosi needs only the level, delayed to line up with the sclk edge pulses
  logic [N_Sync-1:0] mosi_sync_q, mosi_sync_d;
  logic              mosi_s_c;

  always_comb mosi_sync_d = {mosi_sync_q[N_Sync-2:0], mosi};
  assign mosi_s_c = mosi_sync_q[N_Sync-1];

  spi_state_e        state_q, state_d;
  logic              busy_q, busy_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic [W_Data-1:0] rx_shift_q, rx_shift_d;
  logic [W_Data-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [W_Count-1:0] bit_cnt_q, bit_cnt_d;
  logic [W_Data-1:0] tx_shift_q, tx_shift_d;
  logic [W_Data-1:0] tx_buf_q, tx_buf_d;
  logic              tx_ready_q, tx_ready_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic              load_c;
  logic [W_Data-1:0] rx_word_c;

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    overrun_d  = 1'b0;
    underrun_d = 1'b0;
    load_c     = 1'b0;
    rx_word_c  = {rx_shift_q[W_Data-2:0], mosi_s_c};

    if (rx_ack) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (cs_fall_c) begin
          state_d   = ST_ACTIVE;
          busy_d    = 1'b1;
          miso_oe_d = 1'b1;
          bit_cnt_d = '0;
          load_c    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Deselect wins over a coincident sclk edge, so the trailing mode-0
        // fall that accompanies cs_n release is not taken as a word boundary.
        if (cs_rise_c) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
        end else if (sclk_rise_c) begin
          rx_shift_d = rx_word_c;
          if (bit_cnt_q == W_Count'(W_Data - 1)) begin
            rx_data_d  = rx_word_c;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q & ~rx_ack;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + W_Count'(1);
          end
        end else if (sclk_fall_c) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[W_Data-2:0], 1'b0};
            miso_d     = tx_shift_q[W_Data-2];
          end else begin
            load_c = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Word boundary: take the buffered word, or send zeros and flag it
    if (load_c) begin
      if (!tx_ready_q) begin
        tx_shift_d = tx_buf_q;
        tx_ready_d = 1'b1;
        miso_d     = tx_buf_q[W_Data-1];
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
        miso_d     = 1'b0;
      end
    end

    // Buffer capture; only possible while empty, so never races the load
    if (tx_valid && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_ready_q  <= 1'b1;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_ready_q  <= tx_ready_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: a bit-banged mode-0 master with sclk at
// clk/8, CPU-side push/ack helpers, and pulse counters for overrun/underrun.
module tb_spi_slave_port;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, cs_n, mosi;
  logic        miso, miso_oe;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ack;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready;
  logic        busy, overrun, underrun;

  int n_total = 0;
  int n_pass  = 0;
  int und_cnt = 0;
  int ovr_cnt = 0;
  int und0, ovr0;
  logic [31:0] mi, mi2;

  always #5 clk = ~clk;

  spi_slave_port dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overrun  (overrun),
    .underrun (underrun)
  );

  // Count error pulses away from the active edge
  always @(negedge clk) begin
    if (underrun === 1'b1) und_cnt <= und_cnt + 1;
    if (overrun === 1'b1)  ovr_cnt <= ovr_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] v);
    tx_data  = v;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    tick(6);
  endtask

  // cs_n release together with the trailing sclk fall
  task automatic end_frame();
    cs_n = 1'b1;
    sclk = 1'b0;
    tick(6);
  endtask

  // Shift nbits of mo MSB-first; miso sampled at each sclk rise. With last=1
  // sclk is left high after the final bit. ack_last pulses rx_ack on the clk
  // cycle in which the final bit completes the word.
  task automatic xfer(input logic [31:0] mo, input int nbits, input bit last,
                      input bit ack_last, output logic [31:0] mo_in);
    mo_in = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[31-i];
      tick(HALF);
      sclk = 1'b1;
      mo_in[31-i] = miso;
      if (ack_last && i == nbits - 1) begin
        tick(2);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(HALF - 3);
      end else begin
        tick(HALF);
      end
      if (!(last && i == nbits - 1)) sclk = 1'b0;
    end
    tick(HALF);
  endtask

  initial begin
    rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    rx_ack = 1'b0; tx_data = '0; tx_valid = 1'b0;
    tick(3);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b1;
    tick(5);

    // Reset in the middle of a frame
    push(32'h1111_1111);
    start_frame();
    xfer(32'hFFFF_0000, 10, 1'b0, 1'b0, mi);
    rst = 1'b0;
    tick(2);
    chk("midrst_miso_oe", 32'(miso_oe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    cs_n = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(5);

    // Single word
    push(32'hA5A5_0F0F);
    chk("single_tx_full", 32'(tx_ready), 32'd0);
    und0 = und_cnt; ovr0 = ovr_cnt;
    start_frame();
    chk("single_tx_ready_load", 32'(tx_ready), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_miso_oe", 32'(miso_oe), 32'd1);
    xfer(32'h1234_5678, 32, 1'b1, 1'b0, mi);
    end_frame();
    chk("single_rx_data", rx_data, 32'h1234_5678);
    chk("single_rx_valid", 32'(rx_valid), 32'd1);
    chk("single_miso_word", mi, 32'hA5A5_0F0F);
    chk("single_busy_end", 32'(busy), 32'd0);
    chk("single_oe_end", 32'(miso_oe), 32'd0);
    chk("single_underruns", 32'(und_cnt - und0), 32'd0);
    chk("single_overruns", 32'(ovr_cnt - ovr0), 32'd0);
    ack();
    chk("single_ack", 32'(rx_valid), 32'd0);

    // Two back-to-back words in one frame
    push(32'h5555_AAAA);
    und0 = und_cnt; ovr0 = ovr_cnt;
    start_frame();
    push(32'hCAFE_F00D);
    xfer(32'hDEAD_BEEF, 32, 1'b0, 1'b0, mi);
    chk("b2b_rx_data1", rx_data, 32'hDEAD_BEEF);
    chk("b2b_rx_valid1", 32'(rx_valid), 32'd1);
    chk("b2b_miso_word1", mi, 32'h5555_AAAA);
    chk("b2b_tx_reload", 32'(tx_ready), 32'd1);
    ack();
    xfer(32'h0000_0001, 32, 1'b1, 1'b0, mi2);
    end_frame();
    chk("b2b_rx_data2", rx_data, 32'h0000_0001);
    chk("b2b_miso_word2", mi2, 32'hCAFE_F00D);
    chk("b2b_overruns", 32'(ovr_cnt - ovr0), 32'd0);
    chk("b2b_underruns", 32'(und_cnt - und0), 32'd0);
    ack();

    // Underrun: empty buffer at selection
    chk("und_buf_empty", 32'(tx_ready), 32'd1);
    und0 = und_cnt;
    start_frame();
    chk("und_pulse_at_cs", 32'(und_cnt - und0), 32'd1);
    xfer(32'h0F0F_F0F0, 32, 1'b1, 1'b0, mi);
    end_frame();
    chk("und_miso_zero", mi, 32'd0);
    chk("und_pulse_total", 32'(und_cnt - und0), 32'd1);
    chk("und_rx_data", rx_data, 32'h0F0F_F0F0);
    ack();

    // Overrun: no ack between words, then ack on the completion cycle
    ovr0 = ovr_cnt;
    start_frame();
    xfer(32'h1111_2222, 32, 1'b0, 1'b0, mi);
    chk("ovr_first_valid", 32'(rx_valid), 32'd1);
    chk("ovr_none_yet", 32'(ovr_cnt - ovr0), 32'd0);
    xfer(32'h3333_4444, 32, 1'b0, 1'b0, mi);
    chk("ovr_rx_data", rx_data, 32'h3333_4444);
    chk("ovr_pulse", 32'(ovr_cnt - ovr0), 32'd1);
    xfer(32'h5555_6666, 32, 1'b1, 1'b1, mi);
    end_frame();
    chk("ovrack_rx_data", rx_data, 32'h5555_6666);
    chk("ovrack_rx_valid", 32'(rx_valid), 32'd1);
    chk("ovrack_no_pulse", 32'(ovr_cnt - ovr0), 32'd1);
    ack();
    chk("ovr_ack_clear", 32'(rx_valid), 32'd0);

    // Abort after 13 bits, then a clean frame
    start_frame();
    xfer(32'hFFFF_FFFF, 13, 1'b0, 1'b0, mi);
    end_frame();
    chk("abort_rx_valid", 32'(rx_valid), 32'd0);
    chk("abort_miso_oe", 32'(miso_oe), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    start_frame();
    xfer(32'h0000_0003, 32, 1'b1, 1'b0, mi);
    end_frame();
    chk("abort_next_data", rx_data, 32'h0000_0003);
    chk("abort_next_valid", 32'(rx_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
